// File: rtl/pong_pkg.sv
// Types and playfield constants shared by the ball, renderer and AI paddle blocks.
// Lengths are in pixels; ball coordinates are 11-bit row/column values.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SAMPLE,
    ST_PREDICT,
    ST_TRACK
  } ai_state_t;

  localparam int NET_COL_DEF    = 390;
  localparam int REACH_DEF      = 380;
  localparam int SCREEN_H_DEF   = 474;
  localparam int PADDLE_MAX_DEF = 395;
  localparam int CENTER_DEF     = 240;

  function automatic logic [11:0] clamp_hi(input logic [11:0] value, input logic [11:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/ai_intercept_calc.sv
// Combinational intercept predictor: two ball rows sampled one column apart give the
// row where the ball reaches the AI paddle, with at most one wall reflection, clamped.
module ai_intercept_calc
  import pong_pkg::*;
#(
  parameter int REACH      = REACH_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int PADDLE_MAX = PADDLE_MAX_DEF
) (
  input  logic [10:0] i_v0,
  input  logic [10:0] i_v1,
  output logic [8:0]  o_pred
);

  localparam logic [11:0] C_REACH  = 12'(REACH);
  localparam logic [11:0] C_H      = 12'(SCREEN_H);
  localparam logic [11:0] C_TWO_H  = 12'(2 * SCREEN_H);
  localparam logic [11:0] C_MAX    = 12'(PADDLE_MAX);

  logic [11:0] w_v0;
  logic [11:0] w_v1;
  logic [11:0] w_t;
  logic [11:0] w_down;
  logic [11:0] w_up;
  logic [11:0] w_raw;

  assign w_v0 = {1'b0, i_v0};
  assign w_v1 = {1'b0, i_v1};
  assign w_t  = w_v1 + C_REACH;

  // Past a full double height the single-bounce model no longer holds; pin to row 0.
  assign w_down = (w_t <= C_H)     ? w_t :
                  (w_t > C_TWO_H)  ? 12'd0 : (C_TWO_H - w_t);
  assign w_up   = (w_v1 >= C_REACH) ? (w_v1 - C_REACH) : (C_REACH - w_v1);

  assign w_raw  = (w_v1 > w_v0) ? w_down :
                  (w_v1 < w_v0) ? w_up   : w_v1;

  assign o_pred = 9'(clamp_hi(w_raw, C_MAX));

endmodule

// File: rtl/ai_paddle_scheduler.sv
// Computer paddle sequencer: watches the ball cross the net, loads a predicted
// intercept as TARGET and slews the paddle toward it one STEP per tick.
module ai_paddle_scheduler
  import pong_pkg::*;
#(
  parameter int NET_COL    = NET_COL_DEF,
  parameter int REACH      = REACH_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int PADDLE_MAX = PADDLE_MAX_DEF,
  parameter int CENTER     = CENTER_DEF,
  parameter int TICK_DIV   = 500000,
  parameter int STEP       = 1
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [10:0] BALL_H,
  input  logic [10:0] BALL_V,
  output logic [8:0]  TARGET,
  output logic        PRED_VALID,
  output logic        MOVING,
  output logic [7:0]  POSITION
);

  localparam int          CW          = $clog2(TICK_DIV);
  localparam logic [CW-1:0] C_TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [10:0] C_NET       = 11'(NET_COL);
  localparam logic [10:0] C_NET_P1    = 11'(NET_COL + 1);
  localparam logic [10:0] C_NET_M1    = 11'(NET_COL - 1);
  localparam logic [8:0]  C_CENTER    = 9'(CENTER);
  localparam logic [8:0]  C_STEP      = 9'(STEP);

  ai_state_t     r_state;
  ai_state_t     w_state_next;
  logic [CW-1:0] r_cnt;
  logic [8:0]    r_paddle;
  logic [8:0]    w_paddle_next;
  logic [8:0]    r_target;
  logic [8:0]    w_target_next;
  logic [10:0]   r_v0;
  logic [10:0]   w_v0_next;
  logic [10:0]   r_v1;
  logic [10:0]   w_v1_next;
  logic          r_pred_valid;
  logic          w_pred_valid_next;
  logic          r_moving;
  logic          w_moving_next;
  logic          w_tick;
  logic [8:0]    w_pred;

  ai_intercept_calc #(
    .REACH      (REACH),
    .SCREEN_H   (SCREEN_H),
    .PADDLE_MAX (PADDLE_MAX)
  ) u_calc (
    .i_v0   (r_v0),
    .i_v1   (r_v1),
    .o_pred (w_pred)
  );

  assign w_tick = (r_cnt == C_TICK_LAST);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_cnt        <= '0;
      r_state      <= ST_IDLE;
      r_paddle     <= C_CENTER;
      r_target     <= C_CENTER;
      r_v0         <= '0;
      r_v1         <= '0;
      r_pred_valid <= 1'b0;
      r_moving     <= 1'b0;
    end else begin
      r_cnt        <= w_tick ? '0 : r_cnt + 1'b1;
      r_state      <= w_state_next;
      r_paddle     <= w_paddle_next;
      r_target     <= w_target_next;
      r_v0         <= w_v0_next;
      r_v1         <= w_v1_next;
      r_pred_valid <= w_pred_valid_next;
      r_moving     <= w_moving_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_target_next     = r_target;
    w_v0_next         = r_v0;
    w_v1_next         = r_v1;
    w_pred_valid_next = 1'b0;
    if (!ENABLE) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = ST_ARMED;
        ST_ARMED: begin
          w_target_next = C_CENTER;
          if (BALL_H == C_NET) begin
            w_v0_next    = BALL_V;
            w_state_next = ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (BALL_H == C_NET_P1) begin
            w_v1_next    = BALL_V;
            w_state_next = ST_PREDICT;
          end else if (BALL_H == C_NET_M1) begin
            w_state_next = ST_ARMED;
          end
        end
        ST_PREDICT: begin
          w_target_next     = w_pred;
          w_pred_valid_next = 1'b1;
          w_state_next      = ST_TRACK;
        end
        ST_TRACK: begin
          if (BALL_H == C_NET_M1) w_state_next = ST_ARMED;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end

    // Slew toward the TARGET held before this cycle's update; snap when within STEP.
    w_paddle_next = r_paddle;
    if (ENABLE && (r_state != ST_IDLE) && w_tick) begin
      if (r_target > r_paddle)
        w_paddle_next = ((r_target - r_paddle) < C_STEP) ? r_target : r_paddle + C_STEP;
      else if (r_target < r_paddle)
        w_paddle_next = ((r_paddle - r_target) < C_STEP) ? r_target : r_paddle - C_STEP;
    end

    w_moving_next = (w_paddle_next != w_target_next) && (w_state_next != ST_IDLE);
  end

  assign TARGET     = r_target;
  assign PRED_VALID = r_pred_valid;
  assign MOVING     = r_moving;
  assign POSITION   = r_paddle[8:1];

endmodule
